// File: rtl/time_set_pkg.sv
// Shared types and default timing constants for the time-set front panel.
// Also holds the RUN -> SET_HOUR -> SET_MINUTE -> SET_SECOND -> RUN mode order.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SET_HOUR   = 2'd1,
    SET_MINUTE = 2'd2,
    SET_SECOND = 2'd3
  } ts_state_t;

  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 10_000_000;
  localparam int DEF_TIMEOUT       = 500_000_000;
  localparam int DEF_BLINK_HALF    = 25_000_000;

  function automatic ts_state_t next_mode_state(ts_state_t s);
    case (s)
      RUN:        return SET_HOUR;
      SET_HOUR:   return SET_MINUTE;
      SET_MINUTE: return SET_SECOND;
      default:    return RUN;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Step-key edge detector producing a combinational step request for one key.
// Hold-to-repeat counting is compiled in only when TIME_SET_AUTOREPEAT_EN is defined.
module key_repeat
  import time_set_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic enable,
  input  logic inhibit,
  output logic pulse
);

`ifdef TIME_SET_AUTOREPEAT_EN
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY;
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD;
`endif

  logic r_key_q;
  logic w_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_key_q <= 1'b0;
    else        r_key_q <= key;
  end

  assign w_edge = key & ~r_key_q;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_target;
  logic          r_armed;
  logic          r_repeating;
  logic          w_hold;
  logic          w_repeat;

  assign w_hold   = key & enable & ~inhibit;
  assign w_target = r_repeating ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
  assign w_repeat = w_hold & r_armed & (r_cnt == w_target);

  // Counter holds cycles since the last emitted pulse; only a fresh press arms repeating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_repeating <= 1'b0;
    end else if (!w_hold) begin
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_repeating <= 1'b0;
    end else if (w_edge) begin
      r_cnt       <= CW'(1);
      r_armed     <= 1'b1;
      r_repeating <= 1'b0;
    end else if (w_repeat) begin
      r_cnt       <= CW'(1);
      r_repeating <= 1'b1;
    end else if (r_armed && (r_cnt != CW'(CNT_MAX))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign pulse = w_hold & (w_edge | w_repeat);
`else
  assign pulse = key & enable & ~inhibit & w_edge;
`endif

endmodule

// File: rtl/time_set_controller.sv
// Edit-mode sequencer: mode selects, step pulses, inactivity timeout and blink strobe.
// Define TIME_SET_AUTOREPEAT_EN to compile in hold-to-repeat stepping.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int BLINK_HALF    = DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  output logic mode_hour,
  output logic mode_minute,
  output logic mode_second,
  output logic up,
  output logic down,
  output logic blink
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(BLINK_HALF + 1);

  ts_state_t      r_state;
  ts_state_t      w_next_state;
  logic           r_mode_q;
  logic           w_mode_edge;
  logic           w_enable;
  logic           w_up_req;
  logic           w_dn_req;
  logic           w_timeout;
  logic           w_mode_hour_nxt;
  logic           w_mode_minute_nxt;
  logic           w_mode_second_nxt;
  logic [TCW-1:0] r_to_cnt;
  logic [BCW-1:0] r_blink_cnt;

  assign w_mode_edge = btn_mode & ~r_mode_q;
  assign w_enable    = (r_state != RUN);

  // A mode edge or the opposite key being held blocks a step.
`ifdef TIME_SET_AUTOREPEAT_EN
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key_up (
    .clk(clk), .rst_n(rst_n), .key(btn_up), .enable(w_enable),
    .inhibit(w_mode_edge | btn_down), .pulse(w_up_req)
  );
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key_down (
    .clk(clk), .rst_n(rst_n), .key(btn_down), .enable(w_enable),
    .inhibit(w_mode_edge | btn_up), .pulse(w_dn_req)
  );
`else
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);

  key_repeat u_key_up (
    .clk(clk), .rst_n(rst_n), .key(btn_up), .enable(w_enable),
    .inhibit(w_mode_edge | btn_down), .pulse(w_up_req)
  );
  key_repeat u_key_down (
    .clk(clk), .rst_n(rst_n), .key(btn_down), .enable(w_enable),
    .inhibit(w_mode_edge | btn_up), .pulse(w_dn_req)
  );
`endif

  assign w_timeout = (r_state != RUN) && (r_to_cnt == TCW'(TIMEOUT - 1));

  // State register; mode selects are registered from the next state so they move with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_mode_q    <= 1'b0;
      mode_hour   <= 1'b0;
      mode_minute <= 1'b0;
      mode_second <= 1'b0;
      up          <= 1'b0;
      down        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_mode_q    <= btn_mode;
      mode_hour   <= w_mode_hour_nxt;
      mode_minute <= w_mode_minute_nxt;
      mode_second <= w_mode_second_nxt;
      up          <= w_up_req;
      down        <= w_dn_req;
    end
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    if (w_mode_edge)    w_next_state = next_mode_state(r_state);
    else if (w_timeout) w_next_state = RUN;
  end

  always_comb begin
    w_mode_hour_nxt   = (w_next_state == SET_HOUR);
    w_mode_minute_nxt = (w_next_state == SET_MINUTE);
    w_mode_second_nxt = (w_next_state == SET_SECOND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == RUN) || w_mode_edge || w_up_req || w_dn_req) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TCW'(TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + TCW'(1);
    end
  end

  // Blink phase restarts from "shown" on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      blink       <= 1'b0;
    end else if ((r_state == RUN) || (w_next_state != r_state)) begin
      r_blink_cnt <= '0;
      blink       <= 1'b0;
    end else if (r_blink_cnt == BCW'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      blink       <= ~blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BCW'(1);
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed plus random bench for time_set_controller against a cycle-level behavioural model.
// Honours TIME_SET_AUTOREPEAT_EN the same way the design does.
module tb_time_set_controller;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int TO = 40;
  localparam int BH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic mode_hour, mode_minute, mode_second, up, down, blink;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  time_set_controller #(
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .mode_hour(mode_hour), .mode_minute(mode_minute), .mode_second(mode_second),
    .up(up), .down(down), .blink(blink)
  );

  // Model: mode index 0..3, time stamps of press/activity/state entry, expected outputs.
  int m_state, m_t, m_up_since, m_dn_since, m_last_act, m_enter;
  bit m_pm, m_pu, m_pd;
  bit e_up, e_dn, e_blink;
  int n_up, n_dn;

  task automatic check(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit rep_due(int elapsed);
`ifdef TIME_SET_AUTOREPEAT_EN
    return (elapsed == RD) || ((elapsed > RD) && ((elapsed - RD) % RP == 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_pm = 0; m_pu = 0; m_pd = 0;
    m_up_since = -1; m_dn_since = -1; m_last_act = m_t; m_enter = m_t;
    e_up = 0; e_dn = 0; e_blink = 0;
  endtask

  task automatic model_step(bit bm, bit bu, bit bd);
    bit me, is_set, timeout;
    int ns;
    me = bm && !m_pm;
    is_set = (m_state != 0);
    e_up = 0; e_dn = 0;
    if (is_set && !me && !bd && bu) begin
      if (!m_pu) begin e_up = 1; m_up_since = m_t; end
      else if (m_up_since >= 0 && rep_due(m_t - m_up_since)) e_up = 1;
    end
    if (!is_set || me || bd || !bu) m_up_since = -1;
    if (is_set && !me && !bu && bd) begin
      if (!m_pd) begin e_dn = 1; m_dn_since = m_t; end
      else if (m_dn_since >= 0 && rep_due(m_t - m_dn_since)) e_dn = 1;
    end
    if (!is_set || me || bu || !bd) m_dn_since = -1;
    timeout = is_set && ((m_t - m_last_act) == TO);
    ns = me ? (m_state + 1) % 4 : (timeout ? 0 : m_state);
    if (me || e_up || e_dn) m_last_act = m_t;
    if (ns != m_state) m_enter = m_t;
    e_blink = (ns != 0 && ns == m_state) ? (((m_t - m_enter) / BH) % 2 == 1) : 1'b0;
    m_state = ns;
    m_pm = bm; m_pu = bu; m_pd = bd;
    m_t++;
  endtask

  task automatic check_all(string tag);
    check({tag, ".mode_hour"},   mode_hour,   m_state == 1);
    check({tag, ".mode_minute"}, mode_minute, m_state == 2);
    check({tag, ".mode_second"}, mode_second, m_state == 3);
    check({tag, ".up"},          up,          e_up);
    check({tag, ".down"},        down,        e_dn);
    check({tag, ".blink"},       blink,       e_blink);
  endtask

  // Drive after a negedge, let the posedge sample, compare at the following negedge.
  task automatic step(bit bm, bit bu, bit bd, string tag);
    btn_mode = bm; btn_up = bu; btn_down = bd;
    @(posedge clk);
    model_step(bm, bu, bd);
    @(negedge clk);
    check_all(tag);
    if (up) n_up++;
    if (down) n_dn++;
  endtask

  task automatic tap(string tag);
    step(1, 0, 0, tag);
    step(0, 0, 0, tag);
  endtask

  initial begin
    bit bm, bu, bd;
    m_t = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Mode cycling through every SET state back to RUN.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, "tap");
      check("tap_hour",   mode_hour,   i == 0);
      check("tap_minute", mode_minute, i == 1);
      check("tap_second", mode_second, i == 2);
      step(0, 0, 0, "tap_gap");
    end

    // SET_HOUR single up tap.
    tap("to_hour");
    n_up = 0; n_dn = 0;
    step(0, 1, 0, "up_tap");
    repeat (3) step(0, 0, 0, "up_idle");
    check("up_tap_count", n_up == 1, 1'b1);
    check("up_tap_nodown", n_dn == 0, 1'b1);

    // SET_MINUTE held down.
    tap("to_minute");
    n_up = 0; n_dn = 0;
    repeat (20) step(0, 0, 1, "down_hold");
    step(0, 0, 0, "down_rel");
`ifdef TIME_SET_AUTOREPEAT_EN
    check("down_hold_count", n_dn == 4, 1'b1);
`else
    check("down_hold_count", n_dn == 1, 1'b1);
`endif

    // SET_SECOND, both step keys held.
    tap("to_second");
    n_up = 0; n_dn = 0;
    repeat (20) step(0, 1, 1, "both_hold");
    step(0, 0, 0, "both_rel");
    check("both_count", (n_up + n_dn) == 0, 1'b1);

    // Back to RUN, then SET_HOUR idle until timeout.
    tap("to_run");
    tap("to_hour2");
    repeat (44) step(0, 0, 0, "timeout");
    check("timeout_hour", mode_hour, 1'b0);
    check("timeout_blink", blink, 1'b0);

    // Reset during a held up key.
    tap("to_hour3");
    repeat (10) step(0, 1, 0, "rst_hold");
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_hour", mode_hour, 1'b0);
    check("rst_async_up",   up,        1'b0);
    check("rst_async_blink", blink,    1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 1, 0, "post_rst");
    step(0, 0, 0, "post_rst_rel");

    // Random levels with sticky step keys and occasional mode taps.
    bm = 0; bu = 0; bd = 0;
    for (int i = 0; i < 800; i++) begin
      bm = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) bu = ~bu;
      if ($urandom_range(0, 9) == 0) bd = ~bd;
      step(bm, bu, bd, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
